multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB control FSM with memory timeout and halt causes.
// Define MULTICYCLE_MISALIGN_TRAP_EN to trap misaligned loads/stores in EXEC.
module multicycle_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] inst,
   input  logic        mem_ready,
   input  logic [1:0]  addr_lsb,
   output logic        ir_we,
   output logic        pc_we,
   output logic        reg_we,
   output logic        mem_req,
   output logic        mem_we,
   output logic        mem_sel_data,
   output logic        alu_src_imm,
   output logic        wb_from_mem,
   output logic [2:0]  state,
   output logic        halted,
   output logic [1:0]  cause,
   output logic [31:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [1:0] C_ILLEGAL = 2'b01;
   localparam logic [1:0] C_TIMEOUT = 2'b10;
   localparam logic [1:0] C_MISALGN = 2'b11;

   state_t      r_state;
   state_t      w_next;
   logic [7:0]  r_wait;
   logic [7:0]  w_wait_nxt;
   logic [1:0]  r_cause;
   logic [1:0]  w_cause_nxt;
   logic [31:0] r_retired;

   logic w_is_opimm;
   logic w_is_load;
   logic w_is_store;
   logic w_is_ldst;
   logic w_timeout;
   logic w_misalign;

   assign w_is_opimm = (inst[6:0] == 7'b0010011);
   assign w_is_load  = (inst[6:0] == 7'b0000011);
   assign w_is_store = (inst[6:0] == 7'b0100011);
   assign w_is_ldst  = w_is_load | w_is_store;
   assign w_timeout  = (r_wait == 8'(TIMEOUT_CYCLES)) & ~mem_ready;

`ifdef MULTICYCLE_MISALIGN_TRAP_EN
   logic w_unused_inst;
   assign w_unused_inst = ^{inst[31:14], inst[11:7]};
   assign w_misalign = w_is_ldst &
      (((inst[13:12] == 2'b01) & addr_lsb[0]) |
       ((inst[13:12] == 2'b10) & (addr_lsb != 2'b00)));
`else
   logic w_unused_in;
   assign w_unused_in = ^{inst[31:12], inst[11:7], addr_lsb};
   assign w_misalign = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_wait    <= '0;
         r_cause   <= '0;
         r_retired <= '0;
      end else begin
         r_state <= w_next;
         r_wait  <= w_wait_nxt;
         r_cause <= w_cause_nxt;
         if (pc_we) r_retired <= r_retired + 32'd1;
      end
   end

   always_comb begin
      w_next       = r_state;
      w_cause_nxt  = r_cause;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      reg_we       = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_sel_data = 1'b0;
      alu_src_imm  = 1'b0;
      wb_from_mem  = 1'b0;
      unique case (r_state)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_we  = 1'b1;
               w_next = S_DECODE;
            end else if (w_timeout) begin
               w_next      = S_HALT;
               w_cause_nxt = C_TIMEOUT;
            end
         end
         S_DECODE: begin
            if (w_is_opimm | w_is_ldst) begin
               w_next = S_EXEC;
            end else begin
               w_next      = S_HALT;
               w_cause_nxt = C_ILLEGAL;
            end
         end
         S_EXEC: begin
            alu_src_imm = 1'b1;
            if (w_misalign) begin
               w_next      = S_HALT;
               w_cause_nxt = C_MISALGN;
            end else if (w_is_ldst) begin
               w_next = S_MEM;
            end else begin
               w_next = S_WB;
            end
         end
         S_MEM: begin
            mem_req      = 1'b1;
            mem_sel_data = 1'b1;
            mem_we       = w_is_store;
            if (mem_ready) begin
               pc_we  = w_is_store;
               w_next = w_is_store ? S_FETCH : S_WB;
            end else if (w_timeout) begin
               w_next      = S_HALT;
               w_cause_nxt = C_TIMEOUT;
            end
         end
         S_WB: begin
            reg_we      = 1'b1;
            pc_we       = 1'b1;
            wb_from_mem = w_is_load;
            w_next      = S_FETCH;
         end
         S_HALT: begin
            w_next = S_HALT;
         end
         default: begin
            w_next      = S_HALT;
            w_cause_nxt = C_ILLEGAL;
         end
      endcase
   end

   // Counter runs only while stalled in the same memory state; any exit or entry clears it.
   always_comb begin
      w_wait_nxt = '0;
      if ((r_state == S_FETCH || r_state == S_MEM) &&
          !mem_ready && (w_next == r_state))
         w_wait_nxt = r_wait + 8'd1;
   end

   assign state   = r_state;
   assign halted  = (r_state == S_HALT);
   assign cause   = r_cause;
   assign retired = r_retired;

endmodule
